// File: rtl/clk_en_scheduler.sv
// clk_en_scheduler: run/stop clock-enable scheduler with a runtime-reprogrammable
// divisor. Emits a one-cycle tick on the last cycle of each period and a divided
// square wave. A new divisor is only applied at a period boundary, so no runt
// period is ever produced.
//
// Optional feature macro: CLK_EN_BURST_EN
//   When defined, adds burst_len/done ports. A non-zero burst_len sampled on
//   entry to RUN limits the run to that many ticks, after which the scheduler
//   parks in IDLE until enable is dropped and raised again.
//
// A divisor accepted in the tick cycle while the run is also stopping at that
// wrap (enable low, or last burst tick) is written straight to the active
// divisor, exactly as an IDLE write would be, so the next run uses it.
module clk_en_scheduler #(
    parameter int CNT_WIDTH   = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 cfg_valid,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    output logic                 cfg_ready,
    output logic                 cfg_err,
    output logic                 tick,
    output logic                 clk_out,
`ifdef CLK_EN_BURST_EN
    input  logic [CNT_WIDTH-1:0] burst_len,
    output logic                 done,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DIV_RESET = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TWO       = CNT_WIDTH'(2);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] div_q, div_d;
    logic [CNT_WIDTH-1:0] pend_q, pend_d;
    logic                 clk_out_d;
    logic                 cfg_err_d;

    logic xfer;      // config handshake completes this cycle
    logic div_ok;    // requested divisor is usable (>= 2)
    logic take;      // accepted and usable divisor
    logic wrap;      // last cycle of the current period
    logic stop;      // leave RUN/PEND at this wrap
    logic start_ok;  // IDLE may start a run

    assign cfg_ready = (state_q != PEND);
    assign busy      = (state_q != IDLE);
    assign xfer      = cfg_valid && cfg_ready;
    assign div_ok    = (cfg_div >= TWO);
    assign take      = xfer && div_ok;
    // div_q is always >= 2, so div_q - 1 never underflows.
    assign wrap      = busy && (cnt_q == div_q - ONE);
    assign tick      = wrap;

`ifdef CLK_EN_BURST_EN
    logic [CNT_WIDTH-1:0] rem_q, rem_d;    // ticks left in the burst, 0 = continuous
    logic                 hold_q, hold_d;  // burst finished, wait for enable to drop
    logic                 done_d;
    logic                 last_tick;

    assign last_tick = (rem_q == ONE);
    assign stop      = !enable || last_tick;
    assign start_ok  = enable && !hold_q;
`else
    assign stop      = !enable;
    assign start_ok  = enable;
`endif

    // Next-state, counter, divisor and registered-output logic.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        pend_d    = pend_q;
        cfg_err_d = xfer && !div_ok;
`ifdef CLK_EN_BURST_EN
        rem_d     = rem_q;
        hold_d    = hold_q && enable;
        done_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (take) begin
                    div_d = cfg_div;
                end
                if (start_ok) begin
                    state_d = RUN;
`ifdef CLK_EN_BURST_EN
                    rem_d   = burst_len;
`endif
                end
            end
            RUN, PEND: begin
                // Only RUN can accept; a divisor taken in the tick cycle waits
                // for the following wrap.
                if ((state_q == RUN) && take) begin
                    pend_d  = cfg_div;
                    state_d = PEND;
                end
                if (wrap) begin
                    cnt_d = '0;
                    if (state_q == PEND) begin
                        div_d   = pend_q;
                        state_d = RUN;
                    end
                    if (stop) begin
                        state_d = IDLE;
                        if (take) begin
                            div_d = cfg_div;
                        end
                    end
`ifdef CLK_EN_BURST_EN
                    if (last_tick) begin
                        rem_d  = '0;
                        hold_d = 1'b1;
                        done_d = 1'b1;
                    end else if (rem_q != '0) begin
                        rem_d = rem_q - ONE;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Low for the first floor(div/2) counts, so odd divisors stay high longer.
        clk_out_d = (state_d != IDLE) && (cnt_d >= (div_d >> 1));
    end

    // State and output registers; async reset drops any pending divisor.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_RESET;
            pend_q  <= '0;
            clk_out <= 1'b0;
            cfg_err <= 1'b0;
`ifdef CLK_EN_BURST_EN
            rem_q   <= '0;
            hold_q  <= 1'b0;
            done    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // the same pre-edge values, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            clk_out <= clk_out_d;
            cfg_err <= cfg_err_d;
`ifdef CLK_EN_BURST_EN
            rem_q   <= rem_d;
            hold_q  <= hold_d;
            done    <= done_d;
`endif
        end
    end

endmodule

// File: tb/tb_clk_en_scheduler.sv
// Self-checking bench for clk_en_scheduler: directed scenarios with constant
// expectations plus a randomized run against a period/phase reference model.
module tb_clk_en_scheduler;

    localparam int W = 16;

    logic         clk_in    = 1'b0;
    logic         reset_n   = 1'b0;
    logic         enable    = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div   = '0;
    logic         cfg_ready;
    logic         cfg_err;
    logic         tick;
    logic         clk_out;
    logic         busy;
`ifdef CLK_EN_BURST_EN
    logic [W-1:0] burst_len = '0;
    logic         done;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    clk_en_scheduler #(
        .CNT_WIDTH  (W),
        .DEFAULT_DIV(2)
    ) dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .enable   (enable),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .cfg_err  (cfg_err),
        .tick     (tick),
        .clk_out  (clk_out),
`ifdef CLK_EN_BURST_EN
        .burst_len(burst_len),
        .done     (done),
`endif
        .busy     (busy)
    );

    always #5 clk_in = ~clk_in;

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    // Observed output vector: {tick, clk_out, busy, cfg_ready, cfg_err}.
    function automatic logic [4:0] outs();
        return {tick, clk_out, busy, cfg_ready, cfg_err};
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
`ifdef CLK_EN_BURST_EN
        burst_len = '0;
`endif
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic load_div(input int d);
        cfg_valid = 1'b1;
        cfg_div   = W'(d);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        enable  = 1'b1;
        reset_n = 1'b0;
        #3;
        exp = 5'b00010;
        tests_run++;
        if (outs() !== exp) begin
            tests_failed++;
            $display("FAIL reset_held {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b", outs(), exp);
        end
        do_reset();
        tests_run++;
        if (outs() !== exp) begin
            tests_failed++;
            $display("FAIL reset_released {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b", outs(), exp);
        end
    endtask

    task automatic test_default_run();
        logic [4:0] exp;
        do_reset();
        enable = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            exp = {(k % 2 == 1), (k % 2 == 1), 1'b1, 1'b1, 1'b0};
            tests_run++;
            if (outs() !== exp) begin
                tests_failed++;
                $display("FAIL default_run k=%0d {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b", k, outs(), exp);
            end
            step();
        end
    endtask

    task automatic test_idle_config();
        logic [4:0] exp;
        do_reset();
        load_div(5);
        exp = 5'b00010;
        tests_run++;
        if (outs() !== exp) begin
            tests_failed++;
            $display("FAIL idle_config_idle {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b", outs(), exp);
        end
        enable = 1'b1;
        step();
        for (int k = 0; k < 15; k++) begin
            exp = {(k % 5 == 4), (k % 5 >= 2), 1'b1, 1'b1, 1'b0};
            tests_run++;
            if (outs() !== exp) begin
                tests_failed++;
                $display("FAIL idle_config k=%0d {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b", k, outs(), exp);
            end
            step();
        end
    endtask

    task automatic test_reload();
        logic [4:0] exp[4];
        do_reset();
        load_div(4);
        enable = 1'b1;
        step();
        exp[0] = 5'b00110;  // count 0
        exp[1] = 5'b00110;  // count 1, divisor sent here
        exp[2] = 5'b01100;  // count 2, reload pending
        exp[3] = 5'b11100;  // count 3, tick of the old period
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (outs() !== exp[k]) begin
                tests_failed++;
                $display("FAIL reload_cur k=%0d {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b", k, outs(), exp[k]);
            end
            cfg_valid = (k == 1);
            cfg_div   = W'(10);
            step();
        end
        cfg_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            exp[0] = {(k % 10 == 9), (k % 10 >= 5), 1'b1, 1'b1, 1'b0};
            tests_run++;
            if (outs() !== exp[0]) begin
                tests_failed++;
                $display("FAIL reload_new k=%0d {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b", k, outs(), exp[0]);
            end
            step();
        end
    endtask

    task automatic test_bad_div();
        logic [4:0] exp;
        do_reset();
        load_div(6);
        enable = 1'b1;
        step();
        for (int k = 0; k < 24; k++) begin
            exp = {(k % 6 == 5), (k % 6 >= 3), 1'b1, 1'b1, (k == 3 || k == 9)};
            tests_run++;
            if (outs() !== exp) begin
                tests_failed++;
                $display("FAIL bad_div k=%0d {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b", k, outs(), exp);
            end
            cfg_valid = (k == 2 || k == 8);
            cfg_div   = (k == 2) ? W'(1) : W'(0);
            step();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_stop();
        logic [4:0] exp;
        do_reset();
        load_div(8);
        enable = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            exp = {(k == 7), (k >= 4), 1'b1, 1'b1, 1'b0};
            tests_run++;
            if (outs() !== exp) begin
                tests_failed++;
                $display("FAIL stop_finish k=%0d {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b", k, outs(), exp);
            end
            if (k == 2) enable = 1'b0;
            step();
        end
        for (int j = 0; j < 5; j++) begin
            exp = 5'b00010;
            tests_run++;
            if (outs() !== exp) begin
                tests_failed++;
                $display("FAIL stop_idle j=%0d {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b", j, outs(), exp);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_period();
        logic [4:0] exp;
        do_reset();
        load_div(8);
        enable = 1'b1;
        step();
        for (int k = 0; k < 5; k++) step();
        exp = 5'b01110;  // count 5 of 8
        tests_run++;
        if (outs() !== exp) begin
            tests_failed++;
            $display("FAIL mid_reset_before {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b", outs(), exp);
        end
        #2;
        reset_n = 1'b0;
        #1;
        exp = 5'b00010;
        tests_run++;
        if (outs() !== exp) begin
            tests_failed++;
            $display("FAIL mid_reset_async {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b", outs(), exp);
        end
        enable = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tests_run++;
            if (outs() !== exp) begin
                tests_failed++;
                $display("FAIL mid_reset_quiet j=%0d {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b", j, outs(), exp);
            end
            step();
        end
        // The divisor is back to its default of 2 after reset.
        enable = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            exp = {(k % 2 == 1), (k % 2 == 1), 1'b1, 1'b1, 1'b0};
            tests_run++;
            if (outs() !== exp) begin
                tests_failed++;
                $display("FAIL mid_reset_default k=%0d {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b", k, outs(), exp);
            end
            step();
        end
    endtask

    // Divisor offered in the tick cycle takes effect one period later.
    task automatic test_back_to_back();
        logic [4:0] exp;
        int ph, d;
        do_reset();
        load_div(4);
        enable = 1'b1;
        step();
        for (int k = 0; k < 20; k++) begin
            if (k < 8) begin
                d  = 4;
                ph = k % 4;
            end else begin
                d  = 6;
                ph = (k - 8) % 6;
            end
            exp = {(ph == d - 1), (ph >= d / 2), 1'b1, !(k >= 4 && k <= 7), 1'b0};
            tests_run++;
            if (outs() !== exp) begin
                tests_failed++;
                $display("FAIL back_to_back k=%0d {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b", k, outs(), exp);
            end
            cfg_valid = (k == 3);
            cfg_div   = W'(6);
            step();
        end
        cfg_valid = 1'b0;
    endtask

    // Random stimulus against a period/phase model of the scheduler.
    task automatic test_random();
        logic [4:0] exp;
        bit m_run, m_has_pend, m_err, accept, good;
        int m_div, m_ph, m_pend, req;
        do_reset();
        m_run      = 1'b0;
        m_has_pend = 1'b0;
        m_err      = 1'b0;
        m_div      = 2;
        m_ph       = 0;
        m_pend     = 0;
        for (int n = 0; n < 3000; n++) begin
            exp = {(m_run && m_ph == m_div - 1), (m_run && m_ph >= m_div / 2), m_run, !m_has_pend, m_err};
            tests_run++;
            if (outs() !== exp) begin
                tests_failed++;
                $display("FAIL random n=%0d {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b (div=%0d phase=%0d)",
                         n, outs(), exp, m_div, m_ph);
            end
            enable    = ($urandom_range(0, 6) != 0);
            cfg_valid = ($urandom_range(0, 4) == 0);
            req       = $urandom_range(0, 9);
            cfg_div   = W'(req);

            accept = cfg_valid && !m_has_pend;
            good   = accept && (req >= 2);
            m_err  = accept && (req < 2);
            if (!m_run) begin
                if (good) m_div = req;
                if (enable) begin
                    m_run = 1'b1;
                    m_ph  = 0;
                end
            end else if (m_ph == m_div - 1) begin
                m_ph = 0;
                if (m_has_pend) begin
                    m_div      = m_pend;
                    m_has_pend = 1'b0;
                end
                if (!enable) begin
                    m_run = 1'b0;
                    if (good) m_div = req;
                end else if (good) begin
                    m_has_pend = 1'b1;
                    m_pend     = req;
                end
            end else begin
                m_ph = m_ph + 1;
                if (good) begin
                    m_has_pend = 1'b1;
                    m_pend     = req;
                end
            end
            step();
        end
        cfg_valid = 1'b0;
        enable    = 1'b0;
    endtask

`ifdef CLK_EN_BURST_EN
    task automatic test_burst();
        logic [4:0] exp;
        int ticks;
        do_reset();
        load_div(3);
        burst_len = W'(3);
        enable    = 1'b1;
        step();
        ticks = 0;
        for (int k = 0; k < 9; k++) begin
            exp = {(k % 3 == 2), (k % 3 >= 1), 1'b1, 1'b1, 1'b0};
            tests_run++;
            if (outs() !== exp || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL burst_run k=%0d {tick,clk_out,busy,cfg_ready,cfg_err} got %b want %b done=%b", k, outs(), exp, done);
            end
            if (tick === 1'b1) ticks++;
            step();
        end
        tests_run++;
        if (ticks != 3) begin
            tests_failed++;
            $display("FAIL burst_tick_count got %0d want 3", ticks);
        end
        exp = 5'b00010;
        tests_run++;
        if (outs() !== exp || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL burst_done got %b done=%b want %b done=1", outs(), done, exp);
        end
        step();
        for (int j = 0; j < 10; j++) begin
            tests_run++;
            if (outs() !== exp || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL burst_parked j=%0d got %b done=%b want %b done=0", j, outs(), done, exp);
            end
            step();
        end
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        exp = 5'b00110;
        tests_run++;
        if (outs() !== exp) begin
            tests_failed++;
            $display("FAIL burst_restart got %b want %b", outs(), exp);
        end
        enable    = 1'b0;
        burst_len = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_default_run();
        test_idle_config();
        test_reload();
        test_bad_div();
        test_stop();
        test_reset_mid_period();
        test_back_to_back();
        test_random();
`ifdef CLK_EN_BURST_EN
        test_burst();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
